mm_master_sequencer: RTL and testbench

Avalon-MM style initiator that converts single commands from a local command port into one bus read or one bus write. It is the master end for register responders such as the LED blinker controller. The block handles waitrequest stalls, waits for a readdatavalid response, and times out when a responder never answers, for example on an unmapped address. Each command returns one response (read data or completion status) on a valid/ready response port.

---
 rtl/mm_master_sequencer_pkg.sv | 16 +
 rtl/mm_master_sequencer_if.sv | 45 ++++
 rtl/mm_master_sequencer_timeout.sv | 29 ++
 rtl/mm_master_sequencer.sv | 139 +++++++++++++
 tb/tb_mm_master_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_master_sequencer_pkg.sv
// Shared types and constants for the Avalon-MM master sequencer.
// State encoding, timeout counter width and stray counter ceiling.
package mm_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_WAIT,
      RESP
   } mm_state_t;

   localparam int         TIMEOUT_W = 16;
   localparam logic [7:0] STRAY_MAX = 8'hFF;

endpackage

// File: rtl/mm_master_sequencer_if.sv
// Command, response and Avalon-MM bus signals of the sequencer.
// master = sequencer side, slave = command source / bus responder side.
interface mm_master_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_address;
   logic [DATA_W-1:0] cmd_writedata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_readdata;
   logic              rsp_error;

   logic [ADDR_W-1:0] mm_address;
   logic              mm_read;
   logic              mm_write;
   logic [DATA_W-1:0] mm_writedata;
   logic [DATA_W-1:0] mm_readdata;
   logic              mm_readdatavalid;
   logic              mm_waitrequest;

   modport master (
      input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
      output cmd_ready,
      output rsp_valid, rsp_readdata, rsp_error,
      input  rsp_ready,
      output mm_address, mm_read, mm_write, mm_writedata,
      input  mm_readdata, mm_readdatavalid, mm_waitrequest
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_address, cmd_writedata,
      input  cmd_ready,
      input  rsp_valid, rsp_readdata, rsp_error,
      output rsp_ready,
      input  mm_address, mm_read, mm_write, mm_writedata,
      output mm_readdata, mm_readdatavalid, mm_waitrequest
   );

endinterface

// File: rtl/mm_master_sequencer_timeout.sv
// Per-phase cycle counter; expired_o flags the last allowed cycle.
// Saturates so a stuck enable can never wrap back to zero.
module mm_timeout_counter
   import mm_master_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic [TIMEOUT_W-1:0] limit_i,
   output logic                 expired_o
);

   logic [TIMEOUT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && cnt_q != '1) begin
         cnt_q <= cnt_q + TIMEOUT_W'(1);
      end
   end

   // cnt_q counts completed cycles, so this is cycle number limit_i
   assign expired_o = enable_i && (cnt_q >= limit_i - TIMEOUT_W'(1));

endmodule

// File: rtl/mm_master_sequencer.sv
// Avalon-MM master: one command in, one bus access, one response out.
// Request and read-data phases are each bounded by TIMEOUT_CYCLES.
module mm_master_sequencer
   import mm_master_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   mm_master_sequencer_if.master bus,
   output logic [7:0]           stray_count
);

   mm_state_t         state_q;
   logic              cmd_ready_q;
   logic              mm_read_q;
   logic              mm_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rsp_valid_q;
   logic              rsp_error_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [7:0]        stray_q;

   logic tmo_clear;
   logic tmo_enable;
   logic tmo_expired;
   logic rd_accept;
   logic stray_hit;

   assign rd_accept  = (state_q == RD_REQ) && !bus.mm_waitrequest;
   assign tmo_clear  = (state_q == IDLE) || rd_accept;
   assign tmo_enable = (state_q == WR_REQ) || (state_q == RD_REQ)
                    || (state_q == RD_WAIT);
   assign stray_hit  = bus.mm_readdatavalid && (state_q != RD_WAIT)
                    && !rd_accept;

   mm_timeout_counter u_tmo (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_enable),
      .limit_i   (TIMEOUT_W'(TIMEOUT_CYCLES)),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         mm_read_q   <= 1'b0;
         mm_write_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         stray_q     <= '0;
      end else begin
         if (stray_hit && stray_q != STRAY_MAX) begin
            stray_q <= stray_q + 8'd1;
         end
         unique case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  addr_q      <= bus.cmd_address;
                  wdata_q     <= bus.cmd_writedata;
                  cmd_ready_q <= 1'b0;
                  mm_write_q  <= bus.cmd_write;
                  mm_read_q   <= !bus.cmd_write;
                  state_q     <= bus.cmd_write ? WR_REQ : RD_REQ;
               end
            end
            WR_REQ: begin
               // acceptance wins over an expiry in the same cycle
               if (!bus.mm_waitrequest || tmo_expired) begin
                  mm_write_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= bus.mm_waitrequest;
                  rsp_rdata_q <= '0;
                  state_q     <= RESP;
               end
            end
            RD_REQ: begin
               if (!bus.mm_waitrequest) begin
                  mm_read_q <= 1'b0;
                  if (bus.mm_readdatavalid) begin
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b0;
                     rsp_rdata_q <= bus.mm_readdata;
                     state_q     <= RESP;
                  end else begin
                     state_q <= RD_WAIT;
                  end
               end else if (tmo_expired) begin
                  mm_read_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= RESP;
               end
            end
            RD_WAIT: begin
               if (bus.mm_readdatavalid || tmo_expired) begin
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= !bus.mm_readdatavalid;
                  rsp_rdata_q <= bus.mm_readdatavalid ? bus.mm_readdata : '0;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_error_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.mm_read      = mm_read_q;
   assign bus.mm_write     = mm_write_q;
   assign bus.mm_address   = addr_q;
   assign bus.mm_writedata = wdata_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_error    = rsp_error_q;
   assign bus.rsp_readdata = rsp_rdata_q;
   assign stray_count      = stray_q;

endmodule

// File: tb/tb_mm_master_sequencer.sv
// Bench for mm_master_sequencer: directed scenarios plus random
// commands scored against a memory/timeout reference model.
module tb_mm_master_sequencer;

   localparam int T = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] stray_count;

   mm_master_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mm_master_sequencer #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .stray_count (stray_count)
   );

   always #5 clk = ~clk;

   int pass_n  = 0;
   int total_n = 0;

   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   logic [31:0] o_rd;
   logic        o_err;
   logic        o_done;
   logic [31:0] o_addr;
   logic [31:0] o_wdata;
   int          o_req;
   int          o_acc;
   int          o_dat;
   int          o_cyc;
   bit          o_unstable;
   bit          o_both;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one command and act as the bus responder until rsp_valid.
   task automatic run_cmd(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int wt,
                          input int lat);
      int since;
      bit acc;
      bus.cmd_valid     = 1'b1;
      bus.cmd_write     = wr;
      bus.cmd_address   = a;
      bus.cmd_writedata = d;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      o_req = 0; o_acc = 0; o_dat = 0; o_cyc = 0;
      o_unstable = 0; o_both = 0; acc = 0; since = 0;
      o_addr  = bus.mm_address;
      o_wdata = bus.mm_writedata;
      while (!bus.rsp_valid && o_cyc < 200) begin
         bus.mm_readdatavalid = 1'b0;
         bus.mm_readdata      = $urandom;
         if (bus.mm_write && bus.mm_read) o_both = 1;
         if (bus.mm_write || bus.mm_read) begin
            o_req++;
            if (bus.mm_address !== o_addr) o_unstable = 1;
            if (bus.mm_writedata !== o_wdata) o_unstable = 1;
            bus.mm_waitrequest = (o_req <= wt);
            if (o_req > wt) begin
               acc = 1;
               o_acc++;
               if (bus.mm_write) begin
                  bus_mem[bus.mm_address] = bus.mm_writedata;
               end else if (lat == 0) begin
                  bus.mm_readdatavalid = 1'b1;
                  bus.mm_readdata = bus_mem.exists(bus.mm_address) ?
                                    bus_mem[bus.mm_address] : 32'h0;
               end
            end
         end else begin
            bus.mm_waitrequest = 1'($urandom_range(0, 1));
            if (acc && !wr) begin
               since++;
               o_dat++;
               if (since == lat) begin
                  bus.mm_readdatavalid = 1'b1;
                  bus.mm_readdata = bus_mem.exists(bus.mm_address) ?
                                    bus_mem[bus.mm_address] : 32'h0;
               end
            end
         end
         @(negedge clk);
         o_cyc++;
      end
      bus.mm_readdatavalid = 1'b0;
      bus.mm_waitrequest   = 1'b0;
      o_done = bus.rsp_valid;
      o_rd   = bus.rsp_readdata;
      o_err  = bus.rsp_error;
   endtask

   task automatic ack_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 0; bus.cmd_write = 0;
      bus.cmd_address = 0; bus.cmd_writedata = 0;
      bus.rsp_ready = 0; bus.mm_readdata = 0;
      bus.mm_readdatavalid = 0; bus.mm_waitrequest = 1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total_n++;
      if (bus.cmd_ready !== 1'b1)
         $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready);
      else pass_n++;
      total_n++;
      if ({bus.mm_read, bus.mm_write, bus.rsp_valid, bus.rsp_error} !== 4'b0)
         $display("FAIL rst_flags: got %b want 0000",
                  {bus.mm_read, bus.mm_write, bus.rsp_valid, bus.rsp_error});
      else pass_n++;
      total_n++;
      if (stray_count !== 8'd0 || bus.mm_address !== 32'h0)
         $display("FAIL rst_regs: stray %0d addr %h want 0 0",
                  stray_count, bus.mm_address);
      else pass_n++;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_n++;
      if (bus.cmd_ready !== 1'b1 || bus.mm_read !== 1'b0)
         $display("FAIL rst_release: ready %b read %b want 1 0",
                  bus.cmd_ready, bus.mm_read);
      else pass_n++;
   endtask

   task automatic test_write_zero_wait();
      run_cmd(1'b1, 32'h4, 32'hDEADBEEF, 0, 0);
      ref_mem[32'h4] = 32'hDEADBEEF;
      total_n++;
      if (o_done !== 1'b1 || o_req !== 1 || o_cyc !== 1)
         $display("FAIL wr0_timing: done %b req %0d cyc %0d want 1 1 1",
                  o_done, o_req, o_cyc);
      else pass_n++;
      total_n++;
      if (o_addr !== 32'h4 || o_wdata !== 32'hDEADBEEF)
         $display("FAIL wr0_bus: addr %h data %h want 4 deadbeef",
                  o_addr, o_wdata);
      else pass_n++;
      total_n++;
      if (o_err !== 1'b0 || o_rd !== 32'h0)
         $display("FAIL wr0_rsp: err %b rd %h want 0 0", o_err, o_rd);
      else pass_n++;
      ack_rsp();
      total_n++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL wr0_idle: valid %b ready %b want 0 1",
                  bus.rsp_valid, bus.cmd_ready);
      else pass_n++;
   endtask

   task automatic test_write_wait();
      run_cmd(1'b1, 32'h10, 32'h12345678, 3, 0);
      ref_mem[32'h10] = 32'h12345678;
      total_n++;
      if (o_req !== 4 || o_unstable !== 1'b0 || o_acc !== 1)
         $display("FAIL wrw_hold: req %0d unstable %b acc %0d want 4 0 1",
                  o_req, o_unstable, o_acc);
      else pass_n++;
      total_n++;
      if (o_err !== 1'b0 || bus_mem[32'h10] !== 32'h12345678)
         $display("FAIL wrw_rsp: err %b mem %h want 0 12345678",
                  o_err, bus_mem[32'h10]);
      else pass_n++;
      ack_rsp();
   endtask

   task automatic test_read();
      bus_mem[32'h8] = 32'h2A;
      ref_mem[32'h8] = 32'h2A;
      run_cmd(1'b0, 32'h8, 32'h0, 0, 2);
      total_n++;
      if (o_rd !== 32'h2A || o_err !== 1'b0)
         $display("FAIL rd_rsp: rd %h err %b want 2a 0", o_rd, o_err);
      else pass_n++;
      total_n++;
      if (o_req !== 1 || o_dat !== 2)
         $display("FAIL rd_timing: req %0d dat %0d want 1 2", o_req, o_dat);
      else pass_n++;
      ack_rsp();
   endtask

   task automatic test_timeout_stray();
      run_cmd(1'b0, 32'hF00, 32'h0, 0, 1000);
      total_n++;
      if (o_done !== 1'b1 || o_err !== 1'b1 || o_rd !== 32'h0)
         $display("FAIL tmo_rsp: done %b err %b rd %h want 1 1 0",
                  o_done, o_err, o_rd);
      else pass_n++;
      total_n++;
      if (o_dat !== T)
         $display("FAIL tmo_cycles: got %0d want %0d", o_dat, T);
      else pass_n++;
      ack_rsp();
      bus.mm_readdatavalid = 1'b1;
      @(negedge clk);
      bus.mm_readdatavalid = 1'b0;
      total_n++;
      if (stray_count !== 8'd1)
         $display("FAIL tmo_stray: got %0d want 1", stray_count);
      else pass_n++;
      run_cmd(1'b0, 32'h8, 32'h0, 1, 1);
      total_n++;
      if (o_rd !== 32'h2A || o_err !== 1'b0)
         $display("FAIL tmo_next: rd %h err %b want 2a 0", o_rd, o_err);
      else pass_n++;
      ack_rsp();
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      run_cmd(1'b0, 32'h8, 32'h0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b1;
         if (bus.rsp_valid !== 1'b1) bad++;
         if (bus.rsp_readdata !== 32'h2A) bad++;
         if (bus.cmd_ready !== 1'b0) bad++;
         if (bus.mm_write !== 1'b0 || bus.mm_read !== 1'b0) bad++;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      total_n++;
      if (bad !== 0)
         $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
      else pass_n++;
      ack_rsp();
      total_n++;
      if (bus.mm_write !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL bp_release: write %b ready %b want 0 1",
                  bus.mm_write, bus.cmd_ready);
      else pass_n++;
   endtask

   task automatic test_back_to_back();
      bit          wr;
      logic [31:0] a, d, exp_rd;
      int          wt, lat, exp_req, bad_err, bad_rd, bad_req, bad_ack;
      bit          exp_ok;
      bad_err = 0; bad_rd = 0; bad_req = 0; bad_ack = 0;
      for (int i = 0; i < 16; i++) begin
         a = 32'(i) << 2;
         d = $urandom;
         bus_mem[a] = d;
         ref_mem[a] = d;
      end
      for (int n = 0; n < 30; n++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = 32'($urandom_range(0, 15)) << 2;
         d   = $urandom;
         wt  = $urandom_range(0, T);
         lat = $urandom_range(0, T + 2);
         exp_ok  = (wt + 1 <= T) && (wr || lat <= T);
         exp_rd  = (!wr && exp_ok) ? ref_mem[a] : 32'h0;
         exp_req = (wt + 1 <= T) ? wt + 1 : T;
         run_cmd(wr, a, d, wt, lat);
         if (wr && exp_ok) ref_mem[a] = d;
         if (o_done !== 1'b1 || o_err !== !exp_ok) bad_err++;
         if (o_rd !== exp_rd) bad_rd++;
         if (o_req !== exp_req || o_both || o_unstable) bad_req++;
         ack_rsp();
         if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) bad_ack++;
      end
      total_n++;
      if (bad_err !== 0)
         $display("FAIL rnd_err: got %0d mismatches want 0", bad_err);
      else pass_n++;
      total_n++;
      if (bad_rd !== 0)
         $display("FAIL rnd_rdata: got %0d mismatches want 0", bad_rd);
      else pass_n++;
      total_n++;
      if (bad_req !== 0)
         $display("FAIL rnd_req: got %0d mismatches want 0", bad_req);
      else pass_n++;
      total_n++;
      if (bad_ack !== 0)
         $display("FAIL rnd_idle: got %0d mismatches want 0", bad_ack);
      else pass_n++;
      total_n++;
      if (stray_count !== 8'd1)
         $display("FAIL rnd_stray: got %0d want 1", stray_count);
      else pass_n++;
   endtask

   task automatic test_async_reset();
      bus.cmd_valid     = 1'b1;
      bus.cmd_write     = 1'b1;
      bus.cmd_address   = 32'h20;
      bus.cmd_writedata = 32'hA5A5A5A5;
      @(negedge clk);
      bus.cmd_valid      = 1'b0;
      bus.mm_waitrequest = 1'b1;
      repeat (2) @(negedge clk);
      total_n++;
      if (bus.mm_write !== 1'b1)
         $display("FAIL ar_pre: write %b want 1", bus.mm_write);
      else pass_n++;
      #2 rst = 1'b0;
      #1;
      total_n++;
      if (bus.mm_write !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL ar_async: write %b ready %b want 0 1",
                  bus.mm_write, bus.cmd_ready);
      else pass_n++;
      total_n++;
      if (stray_count !== 8'd0)
         $display("FAIL ar_stray: got %0d want 0", stray_count);
      else pass_n++;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_n++;
      if (bus.cmd_ready !== 1'b1 || bus.mm_write !== 1'b0)
         $display("FAIL ar_release: ready %b write %b want 1 0",
                  bus.cmd_ready, bus.mm_write);
      else pass_n++;
      bus.mm_waitrequest = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_write_wait();
      test_read();
      test_timeout_stray();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
